// File: rtl/ram_sp_param_clr.sv
// ram_sp_param_clr
//   Single-port synchronous RAM. The word width and depth are parameters.
//   Reads are registered and flagged with a one-cycle rd_valid strobe.
//   The read-during-write behaviour is selectable.
//   A built-in clear engine writes CLR_VAL into every word after reset and
//   whenever clr is pulsed while the block is idle.
//
// Parameters
//   DATA_W   word width in bits
//   ADDR_W   address width in bits
//   DEPTH    number of words, 1 <= DEPTH <= 2**ADDR_W
//   RD_MODE  0 = read-first (old data), 1 = write-first (new data)
//   CLR_VAL  value written to every word by the clear sweep
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous reset, active-high
//   clr       pulse that starts a clear sweep (ignored while busy)
//   we, re    write / read enable
//   addr      word address shared by read and write
//   data_in   write data
//   data_out  registered read data
//   rd_valid  one-cycle pulse: data_out was updated by a read
//   busy      clear sweep in progress; user accesses are ignored

module ram_sp_param_clr #(
    parameter int                DATA_W  = 4,
    parameter int                ADDR_W  = 8,
    parameter int                DEPTH   = 2**ADDR_W,
    parameter int                RD_MODE = 0,
    parameter logic [DATA_W-1:0] CLR_VAL = {DATA_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    output logic              rd_valid,
    output logic              busy
);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // The sweep pointer is one bit wider than the address so that a
    // full-size array (DEPTH = 2**ADDR_W) can be compared against its last
    // index without the pointer wrapping.
    localparam logic [ADDR_W:0] DEPTH_C    = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] LAST_PTR_C = (ADDR_W+1)'(DEPTH - 1);

    state_t            state_r;
    logic [ADDR_W:0]   clr_ptr_r;
    logic              busy_r;
    logic [DATA_W-1:0] data_out_r;
    logic              rd_valid_r;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              idle_s;
    logic              addr_ok_s;
    logic              wr_en_s;
    logic              rd_en_s;
    logic [DATA_W-1:0] rd_word_s;

    // True when the address falls inside the populated part of the array.
    function automatic logic addr_in_range(input logic [ADDR_W-1:0] a);
        return ({1'b0, a} < DEPTH_C);
    endfunction

    // Access decode and selection of the read word.
    // An out-of-range read returns zero.
    // A write-first collision forwards data_in.
    always_comb begin
        idle_s    = (state_r == ST_IDLE);
        addr_ok_s = addr_in_range(addr);
        wr_en_s   = idle_s & we & addr_ok_s;
        rd_en_s   = idle_s & re;
        if (!addr_ok_s) begin
            rd_word_s = {DATA_W{1'b0}};
        end else if (we && (RD_MODE == 1)) begin
            rd_word_s = data_in;
        end else begin
            rd_word_s = mem[addr];
        end
    end

    // Storage array: either the sweep or a user write, never both.
    always_ff @(posedge clk) begin
        if (state_r == ST_CLEAR) begin
            mem[clr_ptr_r[ADDR_W-1:0]] <= CLR_VAL;
        end else if (wr_en_s) begin
            mem[addr] <= data_in;
        end
    end

    // Clear-engine FSM plus the registered read outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_CLEAR;
            clr_ptr_r  <= {(ADDR_W+1){1'b0}};
            busy_r     <= 1'b1;
            data_out_r <= {DATA_W{1'b0}};
            rd_valid_r <= 1'b0;
        end else begin
            case (state_r)
                ST_CLEAR: begin
                    rd_valid_r <= 1'b0;
                    if (clr_ptr_r == LAST_PTR_C) begin
                        state_r   <= ST_IDLE;
                        busy_r    <= 1'b0;
                        clr_ptr_r <= {(ADDR_W+1){1'b0}};
                    end else begin
                        clr_ptr_r <= clr_ptr_r + {{ADDR_W{1'b0}}, 1'b1};
                    end
                end
                ST_IDLE: begin
                    if (rd_en_s) begin
                        data_out_r <= rd_word_s;
                        rd_valid_r <= 1'b1;
                    end else begin
                        rd_valid_r <= 1'b0;
                    end
                    // The access in this cycle still completes.
                    // The sweep then overwrites it.
                    if (clr) begin
                        state_r   <= ST_CLEAR;
                        clr_ptr_r <= {(ADDR_W+1){1'b0}};
                        busy_r    <= 1'b1;
                    end else begin
                        busy_r    <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= ST_CLEAR;
                    clr_ptr_r  <= {(ADDR_W+1){1'b0}};
                    busy_r     <= 1'b1;
                    rd_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign data_out = data_out_r;
    assign rd_valid = rd_valid_r;
    assign busy     = busy_r;

endmodule

// File: tb/tb_ram_sp_param_clr.sv
// Testbench for ram_sp_param_clr.
// The bench drives two instances with the same inputs:
//   instance 0 uses the default parameters (DEPTH 256, read-first);
//   instance 1 uses DEPTH 200 and write-first.
// A reference model stores each instance's words in a plain array and tracks
// the busy period as a countdown.
// Expected read results are queued when an access is issued.
// A monitor on the falling edge pops and compares them.

module tb_ram_sp_param_clr;

    logic       clk = 1'b0;
    logic       rst, clr, we, re;
    logic [7:0] addr;
    logic [3:0] din;
    logic [3:0] dout [2];
    logic       rv   [2];
    logic       bsy  [2];

    always #5 clk = ~clk;

    ram_sp_param_clr #(.DATA_W(4), .ADDR_W(8)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .re(re), .addr(addr),
        .data_in(din), .data_out(dout[0]), .rd_valid(rv[0]), .busy(bsy[0]));

    ram_sp_param_clr #(.DATA_W(4), .ADDR_W(8), .DEPTH(200), .RD_MODE(1)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .re(re), .addr(addr),
        .data_in(din), .data_out(dout[1]), .rd_valid(rv[1]), .busy(bsy[1]));

    // Reference model
    int         dep  [2] = '{256, 200};
    int         wf   [2] = '{0, 1};
    logic [3:0] mm   [2][256];
    int         busy_left [2];
    logic [3:0] exp_dout  [2];
    logic [3:0] expq0 [$];
    logic [3:0] expq1 [$];
    int         checks = 0;
    int         errors = 0;

    task automatic model_sweep(input int i);
        busy_left[i] = dep[i];
        for (int a = 0; a < 256; a++) mm[i][a] = 4'h0;
    endtask

    task automatic push_exp(input int i, input logic [3:0] v);
        if (i == 0) expq0.push_back(v);
        else        expq1.push_back(v);
    endtask

    // Applies one rising edge to the model, using the inputs present at that edge.
    task automatic model_edge(input int i);
        logic [3:0] v;
        if (rst) begin
            model_sweep(i);
            exp_dout[i] = 4'h0;
        end else if (busy_left[i] > 0) begin
            busy_left[i]--;
        end else begin
            if (re) begin
                if (int'(addr) >= dep[i])  v = 4'h0;
                else if (we && wf[i] == 1) v = din;
                else                       v = mm[i][addr];
                push_exp(i, v);
                exp_dout[i] = v;
            end
            if (we && int'(addr) < dep[i]) mm[i][addr] = din;
            if (clr) model_sweep(i);
        end
    endtask

    task automatic cycle(input logic r, input logic c, input logic w,
                         input logic rd, input logic [7:0] a, input logic [3:0] d);
        @(negedge clk);
        #1;
        rst = r; clr = c; we = w; re = rd; addr = a; din = d;
        @(posedge clk);
        model_edge(0);
        model_edge(1);
    endtask

    // Monitor
    task automatic mon(input int i);
        logic [3:0] e;
        int         qs;
        logic       eb;
        qs = (i == 0) ? expq0.size() : expq1.size();
        eb = (busy_left[i] > 0);
        checks++;
        if (bsy[i] !== eb) begin
            errors++;
            $display("FAIL busy dut%0d t=%0t: got %b required %b", i, $time, bsy[i], eb);
        end
        checks++;
        if (rv[i] === 1'b1) begin
            if (qs == 0) begin
                errors++;
                $display("FAIL rd_valid_unexpected dut%0d t=%0t: got rd_valid=1 required 0", i, $time);
            end else begin
                if (i == 0) e = expq0.pop_front();
                else        e = expq1.pop_front();
                if (dout[i] !== e) begin
                    errors++;
                    $display("FAIL read_data dut%0d t=%0t: got %h required %h", i, $time, dout[i], e);
                end
            end
        end else if (qs != 0) begin
            errors++;
            $display("FAIL rd_valid_missing dut%0d t=%0t: got rd_valid=%b required 1", i, $time, rv[i]);
            if (i == 0) void'(expq0.pop_front());
            else        void'(expq1.pop_front());
        end else if (dout[i] !== exp_dout[i]) begin
            errors++;
            $display("FAIL data_hold dut%0d t=%0t: got %h required %h", i, $time, dout[i], exp_dout[i]);
        end
    endtask

    always @(negedge clk) begin
        mon(0);
        mon(1);
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy_left[0] > 0 || busy_left[1] > 0) && n < 1000) begin
            cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
            n++;
        end
        checks++;
        if (n >= 1000) begin
            errors++;
            $display("FAIL idle_timeout: got still busy required idle within 1000 cycles");
        end
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; we = 1'b0; re = 1'b0; addr = 8'h00; din = 4'h0;
        for (int i = 0; i < 2; i++) begin
            model_sweep(i);
            exp_dout[i] = 4'h0;
        end
        repeat (3) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);

        // Initial sweep: random accesses during busy must be ignored.
        for (int k = 0; k < 256; k++)
            cycle(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)),
                  8'($urandom), 4'($urandom));
        wait_idle();

        // Swept words read back as zero.
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 4'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 4'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'hFF, 4'h0);
        // Write, read back, then hold.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h3C, 4'hA);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h3C, 4'h0);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 4'h0);
        // Read-during-write collision.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h10, 4'hA);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h10, 4'h5);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h10, 4'h0);
        // Depth boundary checks (250 is out of range for instance 1).
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd250, 4'h9);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd250, 4'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'd199, 4'h6);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'd199, 4'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'd220, 4'h3);
        // Clear together with a write; accesses during busy are ignored.
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h20, 4'h7);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 8'h21, 4'hC);
        repeat (5) cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h20, 4'hF);
        wait_idle();
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h20, 4'h0);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h21, 4'h0);

        // Reset in the middle of a sweep.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h05, 4'hB);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 4'h0);
        repeat (99) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            model_sweep(i);
            exp_dout[i] = 4'h0;
        end
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (dout[i] !== 4'h0 || rv[i] !== 1'b0) begin
                errors++;
                $display("FAIL async_reset dut%0d: got data_out=%h rd_valid=%b required 0/0",
                         i, dout[i], rv[i]);
            end
        end
        repeat (2) cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        for (int k = 0; k < 255; k++)
            cycle(1'b0, 1'b0, 1'b0, 1'($urandom_range(1)), 8'($urandom), 4'h0);
        wait_idle();

        // Random traffic.
        for (int k = 0; k < 3000; k++) begin
            logic [7:0] a;
            a = ($urandom_range(3) == 0) ? 8'($urandom) : 8'($urandom_range(15));
            cycle(1'($urandom_range(999) == 0), 1'($urandom_range(299) == 0),
                  1'($urandom_range(1)), 1'($urandom_range(1)), a, 4'($urandom));
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 4'h0);
        @(negedge clk);
        #1;
        checks++;
        if (expq0.size() != 0 || expq1.size() != 0) begin
            errors++;
            $display("FAIL queue_drain: got %0d/%0d pending required 0/0",
                     expq0.size(), expq1.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
